// File: rtl/stopwatch_display.sv
// Converts a binary elapsed-seconds count to HH:MM:SS BCD with a subtract-only FSM,
// and multiplexes the six digits onto a registered active-low 7-segment display.
`timescale 1ns/1ps
module stopwatch_display #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] sec_in,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [23:0] bcd,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [18:0] OVF_LIMIT = 19'd360000;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {IDLE, CAP, HR, MIN, HT, MT, ST, DONE} state_t;

    state_t            r_state, w_nextState;
    logic [18:0]       r_lastVal, r_rem;
    logic              r_ovfNext, r_ovf, r_done;
    logic [6:0]        r_hours;
    logic [5:0]        r_mins;
    logic [3:0]        r_hTens, r_mTens, r_sTens;
    logic [23:0]       r_bcd;

    logic [CNT_W-1:0]  r_scanCnt;
    logic [2:0]        r_nextIdx, r_shownIdx;
    logic [5:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              w_tick, w_refresh, w_dpNext;
    logic [2:0]        w_selIdx;
    logic [3:0]        w_nibble;
    logic [5:0]        w_anNext;
    logic [6:0]        w_segNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Each divide stage stays put while it can still subtract, so latency tracks the digit values.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (sec_in != r_lastVal) w_nextState = CAP;
            CAP:     w_nextState = HR;
            HR:      if (r_rem < 19'd3600) w_nextState = MIN;
            MIN:     if (r_rem < 19'd60)   w_nextState = HT;
            HT:      if (r_hours < 7'd10)  w_nextState = MT;
            MT:      if (r_mins < 6'd10)   w_nextState = ST;
            ST:      if (r_rem < 19'd10)   w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastVal <= '0;
            r_rem     <= '0;
            r_ovfNext <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_hours   <= '0;
            r_mins    <= '0;
            r_hTens   <= '0;
            r_mTens   <= '0;
            r_sTens   <= '0;
            r_bcd     <= '0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                CAP: begin
                    r_lastVal <= sec_in;
                    r_rem     <= (sec_in >= OVF_LIMIT) ? sec_in - OVF_LIMIT : sec_in;
                    r_ovfNext <= (sec_in >= OVF_LIMIT);
                    r_hours   <= '0;
                    r_mins    <= '0;
                    r_hTens   <= '0;
                    r_mTens   <= '0;
                    r_sTens   <= '0;
                end
                HR: if (r_rem >= 19'd3600) begin
                    r_rem   <= r_rem - 19'd3600;
                    r_hours <= r_hours + 7'd1;
                end
                MIN: if (r_rem >= 19'd60) begin
                    r_rem  <= r_rem - 19'd60;
                    r_mins <= r_mins + 6'd1;
                end
                HT: if (r_hours >= 7'd10) begin
                    r_hours <= r_hours - 7'd10;
                    r_hTens <= r_hTens + 4'd1;
                end
                MT: if (r_mins >= 6'd10) begin
                    r_mins  <= r_mins - 6'd10;
                    r_mTens <= r_mTens + 4'd1;
                end
                ST: if (r_rem >= 19'd10) begin
                    r_rem   <= r_rem - 19'd10;
                    r_sTens <= r_sTens + 4'd1;
                end
                DONE: begin
                    r_bcd <= {r_hTens, r_hours[3:0], r_mTens, r_mins[3:0], r_sTens, r_rem[3:0]};
                    r_ovf <= r_ovfNext;
                end
                default: ;
            endcase
        end
    end

    assign w_tick = (r_scanCnt == CNT_LAST);

    // r_nextIdx is the digit the next tick will light; an stays all-off until that first tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scanCnt  <= '0;
            r_nextIdx  <= '0;
            r_shownIdx <= '0;
        end else if (w_tick) begin
            r_scanCnt  <= '0;
            r_nextIdx  <= (r_nextIdx == 3'd5) ? 3'd0 : r_nextIdx + 3'd1;
            r_shownIdx <= r_nextIdx;
        end else begin
            r_scanCnt <= r_scanCnt + 1'b1;
        end
    end

    assign w_selIdx  = w_tick ? r_nextIdx : r_shownIdx;
    assign w_refresh = w_tick || (r_done && (r_an != 6'h3F));

    always_comb begin
        w_nibble = 4'h0;
        case (w_selIdx)
            3'd0:    w_nibble = r_bcd[3:0];
            3'd1:    w_nibble = r_bcd[7:4];
            3'd2:    w_nibble = r_bcd[11:8];
            3'd3:    w_nibble = r_bcd[15:12];
            3'd4:    w_nibble = r_bcd[19:16];
            3'd5:    w_nibble = r_bcd[23:20];
            default: w_nibble = 4'h0;
        endcase
        case (w_nibble)
            4'd0:    w_segNext = 7'h40;
            4'd1:    w_segNext = 7'h79;
            4'd2:    w_segNext = 7'h24;
            4'd3:    w_segNext = 7'h30;
            4'd4:    w_segNext = 7'h19;
            4'd5:    w_segNext = 7'h12;
            4'd6:    w_segNext = 7'h02;
            4'd7:    w_segNext = 7'h78;
            4'd8:    w_segNext = 7'h00;
            4'd9:    w_segNext = 7'h10;
            default: w_segNext = 7'h7F;
        endcase
        if (BLANK_LZ != 0 && w_selIdx == 3'd5 && w_nibble == 4'd0) w_segNext = 7'h7F;
        w_anNext = ~(6'b000001 << w_selIdx);
        w_dpNext = !(w_selIdx == 3'd2 || w_selIdx == 3'd4);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 6'h3F;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_refresh) begin
            r_an  <= w_anNext;
            r_seg <= w_segNext;
            r_dp  <= w_dpNext;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign bcd  = r_bcd;
    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = r_dp;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: expected BCD/ovf/latency come from a division model.
`timescale 1ns/1ps
module tb_stopwatch_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [18:0] sec_in = '0;
    logic        busy, done, ovf, dp;
    logic [23:0] bcd;
    logic [5:0]  an;
    logic [6:0]  seg;

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    stopwatch_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .sec_in(sec_in), .busy(busy), .done(done),
        .ovf(ovf), .bcd(bcd), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [18:0] v);
        int t, h, m, s;
        exp_t e;
        t = (v >= 19'd360000) ? int'(v) - 360000 : int'(v);
        h = t / 3600;
        m = (t % 3600) / 60;
        s = t % 60;
        e.bcd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        e.ovf = (v >= 19'd360000);
        e.lat = h + m + h / 10 + m / 10 + s / 10 + 7;
        return e;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic push_and_drive(input logic [18:0] v);
        @(negedge clk);
        sec_in = v;
        sbq.push_back(model(v));
    endtask

    task automatic wait_done(output int cycles, output bit seen);
        seen = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            cycles = i;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        nVectors++; if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nVectors++; if (done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        nVectors++; if (ovf !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        nVectors++; if (bcd !== 24'h000000) begin nMiscompares++; $display("[TB] FAIL reset_bcd: got %h expected 000000", bcd); end
        nVectors++; if (an !== 6'h3F) begin nMiscompares++; $display("[TB] FAIL reset_an: got %h expected 3f", an); end
        nVectors++; if (seg !== 7'h7F) begin nMiscompares++; $display("[TB] FAIL reset_seg: got %h expected 7f", seg); end
        nVectors++; if (dp !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
    endtask

    task automatic test_idle_zero();
        int busyHits = 0;
        int doneHits = 0;
        sec_in = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (busy) busyHits++;
            if (done) doneHits++;
        end
        nVectors++; if (busyHits != 0) begin nMiscompares++; $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", busyHits); end
        nVectors++; if (doneHits != 0) begin nMiscompares++; $display("[TB] FAIL idle_done: got %0d done pulses expected 0", doneHits); end
        nVectors++; if (bcd !== 24'h000000) begin nMiscompares++; $display("[TB] FAIL idle_bcd: got %h expected 000000", bcd); end
    endtask

    task automatic test_conversions();
        logic [18:0] tbl [0:6];
        exp_t e;
        int c;
        bit seen;
        tbl = '{19'd3725, 19'd359999, 19'd360061, 19'd524287, 19'd60, 19'd86399, 19'd0};
        for (int i = 0; i < 7; i++) begin
            push_and_drive(tbl[i]);
            @(posedge clk);
            #1;
            nVectors++; if (busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL conv_busy[%0d]: got %b expected 1", tbl[i], busy); end
            wait_done(c, seen);
            e = sbq.pop_front();
            nVectors++;
            if (!seen) begin
                nMiscompares++;
                $display("[TB] FAIL conv_timeout[%0d]: got no done expected done within 400 cycles", tbl[i]);
            end else begin
                if (bcd !== e.bcd) begin nMiscompares++; $display("[TB] FAIL conv_bcd[%0d]: got %h expected %h", tbl[i], bcd, e.bcd); end
                nVectors++; if (ovf !== e.ovf) begin nMiscompares++; $display("[TB] FAIL conv_ovf[%0d]: got %b expected %b", tbl[i], ovf, e.ovf); end
                nVectors++; if (c != e.lat) begin nMiscompares++; $display("[TB] FAIL conv_latency[%0d]: got %0d expected %0d", tbl[i], c, e.lat); end
                nVectors++; if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL conv_busy_at_done[%0d]: got %b expected 0", tbl[i], busy); end
                @(posedge clk);
                #1;
                nVectors++; if (done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL conv_done_width[%0d]: got %b expected 0", tbl[i], done); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int c;
        bit seen;
        push_and_drive(19'd3725);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sec_in = 19'd61;
        sbq.push_back(model(19'd61));
        wait_done(c, seen);
        e = sbq.pop_front();
        nVectors++;
        if (!seen) begin
            nMiscompares++;
            $display("[TB] FAIL b2b_first_timeout: got no done expected done");
        end else begin
            if (bcd !== e.bcd) begin nMiscompares++; $display("[TB] FAIL b2b_first_bcd: got %h expected %h", bcd, e.bcd); end
            nVectors++; if (c + 1 != e.lat) begin nMiscompares++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", c + 1, e.lat); end
        end
        wait_done(c, seen);
        e = sbq.pop_front();
        nVectors++;
        if (!seen) begin
            nMiscompares++;
            $display("[TB] FAIL b2b_second_timeout: got no done expected done");
        end else begin
            if (bcd !== e.bcd) begin nMiscompares++; $display("[TB] FAIL b2b_second_bcd: got %h expected %h", bcd, e.bcd); end
            nVectors++; if (ovf !== e.ovf) begin nMiscompares++; $display("[TB] FAIL b2b_second_ovf: got %b expected %b", ovf, e.ovf); end
            nVectors++; if (c - 1 != e.lat) begin nMiscompares++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", c - 1, e.lat); end
        end
    endtask

    task automatic test_abort();
        int doneHits = 0;
        int busyHits = 0;
        @(negedge clk);
        sec_in = 19'd359999;
        repeat (20) @(posedge clk);
        #1;
        nVectors++; if (busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        nVectors++; if (bcd !== 24'h000000) begin nMiscompares++; $display("[TB] FAIL abort_bcd: got %h expected 000000", bcd); end
        nVectors++; if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        nVectors++; if (an !== 6'h3F) begin nMiscompares++; $display("[TB] FAIL abort_an: got %h expected 3f", an); end
        sec_in = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) doneHits++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) doneHits++;
            if (busy) busyHits++;
        end
        nVectors++; if (doneHits != 0) begin nMiscompares++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", doneHits); end
        nVectors++; if (busyHits != 0) begin nMiscompares++; $display("[TB] FAIL abort_restart: got %0d busy cycles expected 0", busyHits); end
    endtask

    task automatic test_scan();
        exp_t e;
        int c;
        bit seen, found;
        logic [5:0] prevAn;
        logic [23:0] shown;
        int d;
        logic [5:0] expAn;
        logic [6:0] expSeg;
        logic expDp;
        push_and_drive(19'd3725);
        wait_done(c, seen);
        e = sbq.pop_front();
        nVectors++;
        if (!seen || bcd !== e.bcd) begin
            nMiscompares++;
            $display("[TB] FAIL scan_setup_bcd: got %h expected %h", bcd, e.bcd);
        end
        shown = e.bcd;
        prevAn = an;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (an == 6'h3E && prevAn != 6'h3E) begin
                found = 1'b1;
                break;
            end
            prevAn = an;
        end
        nVectors++;
        if (!found) begin
            nMiscompares++;
            $display("[TB] FAIL scan_start: got an=%h expected a transition to 3e", an);
        end else begin
            for (int k = 0; k < 24; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                d = k / 4;
                expAn = ~(6'b000001 << d);
                expSeg = seg_of(shown[d*4 +: 4]);
                if (d == 5 && shown[23:20] == 4'd0) expSeg = 7'h7F;
                expDp = !(d == 2 || d == 4);
                nVectors++; if (an !== expAn) begin nMiscompares++; $display("[TB] FAIL scan_an[%0d]: got %h expected %h", k, an, expAn); end
                nVectors++; if (seg !== expSeg) begin nMiscompares++; $display("[TB] FAIL scan_seg[%0d]: got %h expected %h", k, seg, expSeg); end
                nVectors++; if (dp !== expDp) begin nMiscompares++; $display("[TB] FAIL scan_dp[%0d]: got %b expected %b", k, dp, expDp); end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        nVectors++; if (an !== 6'h3F) begin nMiscompares++; $display("[TB] FAIL scan_reset_an: got %h expected 3f", an); end
        nVectors++; if (seg !== 7'h7F) begin nMiscompares++; $display("[TB] FAIL scan_reset_seg: got %h expected 7f", seg); end
        nVectors++; if (dp !== 1'b1) begin nMiscompares++; $display("[TB] FAIL scan_reset_dp: got %b expected 1", dp); end
        sec_in = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        $display("[TB] stopwatch_display bench start");
        test_reset();
        test_idle_zero();
        test_conversions();
        test_back_to_back();
        test_abort();
        test_scan();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each display digit is held.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, meaning the hours-tens digit is blanked when it is zero.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 The block SHALL have port sec_in, input, 19, elapsed seconds from the stopwatch (binary).
REQ-006 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1, one-cycle pulse when bcd updates.
REQ-008 The block SHALL have port ovf, output, 1, set when the captured sec_in was >= 360000.
REQ-009 The block SHALL have port bcd, output, 24, HH:MM:SS packed as {Ht,Ho,Mt,Mo,St,So}, 4 bits per digit.
REQ-010 The block SHALL have port an, output, 6, active-low digit enables; an[0] = seconds ones, an[5] = hours tens.
REQ-011 The block SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-012 The block SHALL have port dp, output, 1, active-low decimal point.

Function
REQ-013 The block SHALL hold register last_val (19 bits) and SHALL start a conversion from IDLE when sec_in != last_val.
REQ-014 The FSM SHALL have states IDLE, CAP, HR, MIN, HT, MT, ST and DONE.
REQ-015 CAP SHALL load last_val <= sec_in, rem <= (sec_in >= 360000) ? sec_in - 360000 : sec_in, and ovf_next <= (sec_in >= 360000).
  - After one cycle CAP SHALL go to HR.
REQ-016 In HR, each cycle with rem >= 3600 SHALL subtract 3600 and increment hours (7 bits); otherwise the FSM SHALL go to MIN.
REQ-017 MIN SHALL apply the same rule with divisor 60 into minutes (6 bits); the remaining rem (0..59) SHALL be the seconds value.
REQ-018 HT, MT and ST SHALL each split hours, minutes and seconds into tens and ones by subtracting 10 once per cycle, then advance (HT->MT->ST->DONE).
REQ-019 DONE SHALL update bcd and ovf together (atomic, never partially updated), pulse done for one cycle, and return to IDLE.
REQ-020 Latency from the IDLE->CAP cycle to the done pulse SHALL be h + m + ht + mt + st + 7 cycles.
  - h, m = hours and minutes quotients; ht, mt, st = the tens digits.
  - Worst case SHALL be 184 cycles (99:59:59).
REQ-021 busy SHALL be high in every state except IDLE.
REQ-022 Changes of sec_in during a conversion SHALL be ignored; the FSM SHALL check for a new value on its first IDLE cycle after DONE.
REQ-023 Hours SHALL never exceed 99.
  - Inputs 360000..524287 SHALL display (sec_in - 360000) with ovf = 1.
REQ-024 A free-running scan counter SHALL advance the digit index 0..5 every SCAN_DIV cycles and wrap from 5 to 0.
REQ-025 Exactly one an bit SHALL be low at a time after the first scan tick following reset.
REQ-026 seg SHALL decode the bcd nibble of the selected digit to standard 7-segment 0..9.
  - Nibbles 10..15 SHALL show all segments off.
REQ-027 When BLANK_LZ = 1 and Ht = 0, digit 5 SHALL show seg = 7'h7F.
REQ-028 dp SHALL be low only on digits 2 and 4 (the HH.MM.SS separators).
REQ-029 seg, an and dp SHALL be registered and change only on a scan tick or a bcd update.

Reset
REQ-030 While reset = 0, the FSM SHALL be IDLE and last_val, rem, bcd and the counters SHALL be 0.
  - busy, done and ovf SHALL be 0.
  - an SHALL be 6'h3F, seg 7'h7F and dp 1.
REQ-031 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; bcd SHALL read 0.
REQ-032 After reset release with sec_in = 0, no conversion SHALL start.

Verification
REQ-033 Scenario: reset, then sec_in = 0 for 1000 cycles -> busy stays 0, bcd = 24'h000000, no done pulse.
REQ-034 Scenario: sec_in = 3725 -> done 10 cycles after CAP, bcd = 24'h010205, ovf = 0.
REQ-035 Scenario: sec_in = 359999 -> done after 184 cycles, bcd = 24'h995959, ovf = 0.
REQ-036 Scenario: sec_in = 360061 -> bcd = 24'h000101, ovf = 1.
REQ-037 Scenario: sec_in changes 3725->61 during HR -> first done gives 24'h010205, then a second conversion gives 24'h000101.
REQ-038 Scenario: SCAN_DIV = 4, bcd = 24'h010205 -> an cycles 3E,3D,3B,37,2F,1F (each held 4 cycles).
  - Digit 5 is blanked; dp is low on an = 3B and 2F.
  - Reset asserted mid-scan returns an to 3F.
